// File: rtl/ahb_si_arbiter_slave_if.sv
// Request/response bundle between the masters' decoder outputs and one slave-port arbiter.
interface ahb_si_arbiter_slave_if #(
  parameter int MASTER_NUM = 4,
  parameter int PAYLOAD    = 78
);
  logic [MASTER_NUM-1:0]              hreq;
  logic [MASTER_NUM-1:0][PAYLOAD-1:0] payload_in;
  logic                               hready_in;
  logic [PAYLOAD-1:0]                 payload_out;
  logic [MASTER_NUM-1:0]              hgrant;
  logic [MASTER_NUM-1:0]              data_sel;

  modport master (output hreq, payload_in, hready_in, input payload_out, hgrant, data_sel);
  modport slave  (input hreq, payload_in, hready_in, output payload_out, hgrant, data_sel);
endinterface

// File: rtl/ahb_si_arbiter_slave.sv
// Round-robin arbiter and request mux for one AHB slave port; bursts and locked sequences keep the grant.
// Grant is registered (1 cycle from request); wait states (hready_in=0) freeze grant, pointer, beats and data phase.
module ahb_si_arbiter_slave #(
  parameter int MASTER_NUM     = 4,
  parameter int PAYLOAD        = 78,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_si_arbiter_slave_if.slave bus
);
  localparam int PW       = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int WD_LO    = 14;
  localparam int TR_LO    = 12;
  localparam int BURST_LO = 5;
  localparam logic [PAYLOAD-1:0] WD_MASK = {{(PAYLOAD-32){1'b0}}, 32'hFFFF_FFFF} << WD_LO;

  localparam logic [1:0] HT_BUSY   = 2'd1;
  localparam logic [1:0] HT_NONSEQ = 2'd2;
  localparam logic [1:0] HT_SEQ    = 2'd3;
  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;

  logic [MASTER_NUM-1:0] r_hgrant;
  logic [MASTER_NUM-1:0] r_data_sel;
  logic [PW-1:0]         r_ptr;
  logic [3:0]            r_beats;

  logic [MASTER_NUM-1:0] w_hgrant_nxt;
  logic [PW-1:0]         w_ptr_nxt;
  logic [PW-1:0]         w_idx;
  logic [PW-1:0]         w_owner;
  logic [PW-1:0]         w_didx;
  logic                  w_found;
  logic                  w_owner_vld;
  logic                  w_accept;
  logic                  w_hold;
  logic [PAYLOAD-1:0]    w_req;
  logic [31:0]           w_hwdata;
  logic [1:0]            w_trans;
  logic [2:0]            w_burst;
  logic                  w_lock;
  logic [3:0]            w_beats_load;

  always_comb begin
    w_owner = '0;
    w_didx  = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (r_hgrant[i])   w_owner = PW'(i);
      if (r_data_sel[i]) w_didx  = PW'(i);
    end
  end

  // A granted master that drops hreq is treated as IDLE so nothing stale reaches the slave.
  assign w_owner_vld = (|r_hgrant) && bus.hreq[w_owner];
  assign w_req       = w_owner_vld ? bus.payload_in[w_owner] : '0;
  assign w_hwdata    = (|r_data_sel) ? bus.payload_in[w_didx][WD_LO +: 32] : 32'd0;
  assign w_trans     = w_req[TR_LO +: 2];
  assign w_burst     = w_req[BURST_LO +: 3];
  assign w_lock      = w_req[0];

  assign bus.payload_out = (w_req & ~WD_MASK) | (PAYLOAD'(w_hwdata) << WD_LO);
  assign bus.hgrant      = r_hgrant;
  assign bus.data_sel    = r_data_sel;

  assign w_accept = bus.hready_in && w_owner_vld && w_trans[1];
  assign w_hold   = w_owner_vld &&
                    (w_lock || (w_trans == HT_BUSY) ||
                     ((w_trans == HT_NONSEQ) && (w_burst != HB_SINGLE)) ||
                     ((w_trans == HT_SEQ) && ((w_burst == HB_INCR) || (r_beats > 4'd1))));

  always_comb begin
    case (w_burst)
      3'd2, 3'd3: w_beats_load = 4'd3;
      3'd4, 3'd5: w_beats_load = 4'd7;
      3'd6, 3'd7: w_beats_load = 4'd15;
      default:    w_beats_load = 4'd0;
    endcase
  end

  // Scan from the pointer with wrap-around; the previous winner sits last in that order.
  always_comb begin
    w_hgrant_nxt = '0;
    w_ptr_nxt    = r_ptr;
    w_found      = 1'b0;
    w_idx        = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % MASTER_NUM);
      if (!w_found && bus.hreq[w_idx]) begin
        w_found             = 1'b1;
        w_hgrant_nxt[w_idx] = 1'b1;
        w_ptr_nxt           = (w_idx == PW'(MASTER_NUM - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hgrant   <= '0;
      r_data_sel <= '0;
      r_beats    <= '0;
      r_ptr      <= PW'(DEFAULT_MASTER);
    end else if (bus.hready_in) begin
      r_data_sel <= w_accept ? r_hgrant : '0;
      if (!w_hold) begin
        r_hgrant <= w_hgrant_nxt;
        r_ptr    <= w_ptr_nxt;
      end
      if (w_accept) begin
        if (w_trans == HT_NONSEQ)  r_beats <= w_beats_load;
        else if (r_beats != 4'd0)  r_beats <= r_beats - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_ahb_si_arbiter_slave.sv
// Directed scenarios for the slave-port arbiter; expectations go into a queue, a negedge monitor compares.
module tb_ahb_si_arbiter_slave;
  localparam logic [1:0] HT_IDLE = 2'd0, HT_NONSEQ = 2'd2, HT_SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, WRAP8 = 3'd4, INCR8 = 3'd5;

  logic clk = 1'b1;
  logic rst_n;

  ahb_si_arbiter_slave_if #(.MASTER_NUM(4), .PAYLOAD(78)) bus ();

  ahb_si_arbiter_slave #(.MASTER_NUM(4), .PAYLOAD(78), .DEFAULT_MASTER(0)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  g;
    logic [3:0]  ds;
    logic [1:0]  tr;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [3:0]  bl;
  } obs_t;

  typedef struct {
    string name;
    obs_t  e;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [77:0] mk(input logic [31:0] a, input logic [31:0] w,
                                     input logic [1:0] t, input logic [2:0] b);
    return {a, w, t, 1'b1, 3'b010, b, 4'b0011, 1'b0};
  endfunction

  function automatic logic [31:0] ad(input int m, input int b);
    return 32'h1000_0000 | (32'(m) << 12) | (32'(b) << 2);
  endfunction

  function automatic logic [31:0] wd(input int m, input int b);
    return 32'hD000_0000 | (32'(m) << 8) | 32'(b);
  endfunction

  task automatic ex(input string nm, input logic [3:0] g, input logic [3:0] ds, input logic [1:0] tr,
                    input logic [31:0] a, input logic [31:0] w, input logic [3:0] bl);
    exp_t e;
    e.name = nm;
    e.e    = '{g: g, ds: ds, tr: tr, ad: a, wd: w, bl: bl};
    sbq.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.hreq      = '0;
    bus.hready_in = 1'b1;
    for (int m = 0; m < 4; m++) bus.payload_in[m] = '0;
    ex("reset", 4'b0, 4'b0, HT_IDLE, 32'd0, 32'd0, 4'd0);
    nxt();
    rst_n = 1'b1;
  endtask

  // Monitor: one observation per falling edge whenever an expectation is pending.
  initial begin
    exp_t m_e;
    obs_t m_a;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        m_e  = sbq.pop_front();
        m_a  = '{g: bus.hgrant, ds: bus.data_sel, tr: bus.payload_out[13:12],
                 ad: bus.payload_out[77:46], wd: bus.payload_out[45:14], bl: dut.r_beats};
        n_vec++;
        if (m_a !== m_e.e) begin
          n_err++;
          $display("FAIL %s: got g=%b ds=%b tr=%0d ad=%h wd=%h bl=%0d, want g=%b ds=%b tr=%0d ad=%h wd=%h bl=%0d",
                   m_e.name, m_a.g, m_a.ds, m_a.tr, m_a.ad, m_a.wd, m_a.bl,
                   m_e.e.g, m_e.e.ds, m_e.e.tr, m_e.e.ad, m_e.e.wd, m_e.e.bl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single transfer from master1
    do_reset();
    bus.hreq = 4'b0010;
    bus.payload_in[1] = mk(ad(1,0), wd(1,0), HT_NONSEQ, SINGLE);
    ex("t1_req", 4'b0000, 4'b0000, HT_IDLE, 32'd0, 32'd0, 4'd0);
    nxt();
    ex("t1_grant", 4'b0010, 4'b0000, HT_NONSEQ, ad(1,0), 32'd0, 4'd0);
    nxt();
    bus.hreq = 4'b0000;
    bus.payload_in[1] = mk(32'd0, wd(1,0), HT_IDLE, SINGLE);
    ex("t1_data", 4'b0010, 4'b0010, HT_IDLE, 32'd0, wd(1,0), 4'd0);
    nxt();
    ex("t1_idle", 4'b0000, 4'b0000, HT_IDLE, 32'd0, 32'd0, 4'd0);
    nxt();

    // Round robin among four single-beat requesters
    do_reset();
    bus.hreq = 4'b1111;
    for (int m = 0; m < 4; m++) bus.payload_in[m] = mk(ad(m,0), wd(m,0), HT_NONSEQ, SINGLE);
    ex("t2_c0", 4'b0000, 4'b0000, HT_IDLE, 32'd0, 32'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      int ow, pv;
      nxt();
      ow = (k - 1) % 4;
      pv = (k + 2) % 4;
      ex($sformatf("t2_rr%0d", k), 4'(1 << ow), (k == 1) ? 4'b0 : 4'(1 << pv), HT_NONSEQ,
         ad(ow,0), (k == 1) ? 32'd0 : wd(pv,0), 4'd0);
    end
    nxt();

    // INCR4 from master2 holds the grant while master0 waits
    do_reset();
    bus.hreq = 4'b0100;
    bus.payload_in[2] = mk(ad(2,0), 32'd0, HT_NONSEQ, INCR4);
    ex("t3_c0", 4'b0000, 4'b0000, HT_IDLE, 32'd0, 32'd0, 4'd0);
    nxt();
    bus.hreq = 4'b0101;
    bus.payload_in[0] = mk(ad(0,0), 32'd0, HT_NONSEQ, SINGLE);
    ex("t3_nonseq", 4'b0100, 4'b0000, HT_NONSEQ, ad(2,0), 32'd0, 4'd0);
    for (int b = 1; b <= 3; b++) begin
      nxt();
      bus.payload_in[2] = mk(ad(2,b), wd(2,b-1), HT_SEQ, INCR4);
      ex($sformatf("t3_seq%0d", b), 4'b0100, 4'b0100, HT_SEQ, ad(2,b), wd(2,b-1), 4'(4 - b));
    end
    nxt();
    bus.hreq = 4'b0001;
    bus.payload_in[2] = mk(32'd0, wd(2,3), HT_IDLE, SINGLE);
    ex("t3_handover", 4'b0001, 4'b0100, HT_NONSEQ, ad(0,0), wd(2,3), 4'd0);
    nxt();

    // Wait states in the middle of an INCR4
    do_reset();
    bus.hreq = 4'b0100;
    bus.payload_in[2] = mk(ad(2,0), 32'd0, HT_NONSEQ, INCR4);
    ex("t4_c0", 4'b0000, 4'b0000, HT_IDLE, 32'd0, 32'd0, 4'd0);
    nxt();
    ex("t4_nonseq", 4'b0100, 4'b0000, HT_NONSEQ, ad(2,0), 32'd0, 4'd0);
    nxt();
    bus.payload_in[2] = mk(ad(2,1), wd(2,0), HT_SEQ, INCR4);
    ex("t4_seq1", 4'b0100, 4'b0100, HT_SEQ, ad(2,1), wd(2,0), 4'd3);
    nxt();
    bus.hreq = 4'b0101;
    bus.payload_in[0] = mk(ad(0,0), 32'd0, HT_NONSEQ, SINGLE);
    bus.payload_in[2] = mk(ad(2,2), wd(2,1), HT_SEQ, INCR4);
    bus.hready_in = 1'b0;
    for (int w = 0; w < 3; w++) begin
      ex($sformatf("t4_wait%0d", w), 4'b0100, 4'b0100, HT_SEQ, ad(2,2), wd(2,1), 4'd2);
      nxt();
    end
    bus.hready_in = 1'b1;
    ex("t4_resume", 4'b0100, 4'b0100, HT_SEQ, ad(2,2), wd(2,1), 4'd2);
    nxt();
    bus.payload_in[2] = mk(ad(2,3), wd(2,2), HT_SEQ, INCR4);
    ex("t4_last", 4'b0100, 4'b0100, HT_SEQ, ad(2,3), wd(2,2), 4'd1);
    nxt();
    bus.hreq = 4'b0001;
    bus.payload_in[2] = mk(32'd0, wd(2,3), HT_IDLE, SINGLE);
    ex("t4_handover", 4'b0001, 4'b0100, HT_NONSEQ, ad(0,0), wd(2,3), 4'd0);
    nxt();

    // INCR8 from master1 cut short by IDLE; master3 takes over
    do_reset();
    bus.hreq = 4'b0010;
    bus.payload_in[1] = mk(ad(1,0), 32'd0, HT_NONSEQ, INCR8);
    ex("t5_c0", 4'b0000, 4'b0000, HT_IDLE, 32'd0, 32'd0, 4'd0);
    nxt();
    bus.hreq = 4'b1010;
    bus.payload_in[3] = mk(ad(3,0), 32'd0, HT_NONSEQ, SINGLE);
    ex("t5_nonseq", 4'b0010, 4'b0000, HT_NONSEQ, ad(1,0), 32'd0, 4'd0);
    nxt();
    bus.payload_in[1] = mk(ad(1,1), wd(1,0), HT_SEQ, INCR8);
    ex("t5_seq1", 4'b0010, 4'b0010, HT_SEQ, ad(1,1), wd(1,0), 4'd7);
    nxt();
    bus.payload_in[1] = mk(ad(1,2), wd(1,1), HT_SEQ, INCR8);
    ex("t5_seq2", 4'b0010, 4'b0010, HT_SEQ, ad(1,2), wd(1,1), 4'd6);
    nxt();
    bus.payload_in[1] = mk(ad(1,3), wd(1,2), HT_IDLE, INCR8);
    ex("t5_idle", 4'b0010, 4'b0010, HT_IDLE, ad(1,3), wd(1,2), 4'd5);
    nxt();
    bus.hreq = 4'b1000;
    ex("t5_newowner", 4'b1000, 4'b0000, HT_NONSEQ, ad(3,0), 32'd0, 4'd5);
    nxt();
    bus.payload_in[3] = mk(32'd0, wd(3,0), HT_IDLE, SINGLE);
    ex("t5_reload", 4'b1000, 4'b1000, HT_IDLE, 32'd0, wd(3,0), 4'd0);
    nxt();

    // Asynchronous reset during a stalled WRAP8
    do_reset();
    bus.hreq = 4'b0100;
    bus.payload_in[2] = mk(ad(2,0), 32'd0, HT_NONSEQ, WRAP8);
    ex("t6_c0", 4'b0000, 4'b0000, HT_IDLE, 32'd0, 32'd0, 4'd0);
    nxt();
    ex("t6_nonseq", 4'b0100, 4'b0000, HT_NONSEQ, ad(2,0), 32'd0, 4'd0);
    nxt();
    bus.payload_in[2] = mk(ad(2,1), wd(2,0), HT_SEQ, WRAP8);
    ex("t6_seq1", 4'b0100, 4'b0100, HT_SEQ, ad(2,1), wd(2,0), 4'd7);
    nxt();
    bus.hready_in = 1'b0;
    bus.payload_in[2] = mk(ad(2,2), wd(2,1), HT_SEQ, WRAP8);
    ex("t6_stall", 4'b0100, 4'b0100, HT_SEQ, ad(2,2), wd(2,1), 4'd6);
    nxt();
    rst_n = 1'b0;
    bus.hreq = 4'b1100;
    bus.payload_in[2] = mk(ad(2,0), 32'd0, HT_NONSEQ, SINGLE);
    bus.payload_in[3] = mk(ad(3,0), 32'd0, HT_NONSEQ, SINGLE);
    ex("t6_async_rst", 4'b0000, 4'b0000, HT_IDLE, 32'd0, 32'd0, 4'd0);
    nxt();
    rst_n = 1'b1;
    bus.hready_in = 1'b1;
    ex("t6_release", 4'b0000, 4'b0000, HT_IDLE, 32'd0, 32'd0, 4'd0);
    nxt();
    ex("t6_default_prio", 4'b0100, 4'b0000, HT_NONSEQ, ad(2,0), 32'd0, 4'd0);
    nxt();

    @(negedge clk);
    #1;
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
